// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: packs little-endian bytes into 32-bit
// words, writes them to IMEM, then releases the CPU until HALT_PC or timeout.
module imem_loader #(
  parameter int unsigned ADDR_W     = 8,
  parameter logic [31:0] HALT_PC    = 32'h80000078,
  parameter logic [31:0] MAX_CYCLES = 32'd100000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rstn,
  input  logic [31:0]       cpu_pc,
  output logic              running,
  output logic              halted,
  output logic              err,
  output logic [ADDR_W:0]   word_count,
  output logic [31:0]       cycle_count
);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, RUN, HALT} state_t;

  state_t            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       buf_q, buf_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [31:0]       cycle_cnt_q, cycle_cnt_d;
  logic              err_q, err_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      byte_idx_q  <= '0;
      buf_q       <= '0;
      last_q      <= 1'b0;
      addr_q      <= '0;
      word_cnt_q  <= '0;
      cycle_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      buf_q       <= buf_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      word_cnt_q  <= word_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    buf_d       = buf_q;
    last_d      = last_q;
    addr_d      = addr_q;
    word_cnt_d  = word_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    err_d       = err_q;
    s_ready     = 1'b0;
    imem_we     = 1'b0;
    cpu_rstn    = 1'b0;
    running     = 1'b0;
    halted      = 1'b0;

    unique case (state_q)
      IDLE, HALT: begin
        halted = (state_q == HALT);
        if (start) begin
          state_d     = LOAD;
          byte_idx_d  = '0;
          last_d      = 1'b0;
          addr_d      = '0;
          word_cnt_d  = '0;
          cycle_cnt_d = '0;
          err_d       = 1'b0;
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          // First byte of a word clears the buffer so a short final word is zero-padded.
          if (byte_idx_q == 2'd0) buf_d = '0;
          buf_d[{byte_idx_q, 3'b000} +: 8] = s_data;
          byte_idx_d = byte_idx_q + 2'd1;
          last_d     = s_last;
          if (byte_idx_q == 2'd3 || s_last) state_d = WRITE;
        end
      end
      WRITE: begin
        imem_we    = 1'b1;
        word_cnt_d = word_cnt_q + (ADDR_W+1)'(1);
        if (last_q) begin
          state_d = RUN;
        end else if (addr_q == '1) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          addr_d     = addr_q + ADDR_W'(1);
          byte_idx_d = '0;
          state_d    = LOAD;
        end
      end
      RUN: begin
        cpu_rstn    = 1'b1;
        running     = 1'b1;
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        if (cpu_pc == HALT_PC) begin
          state_d = HALT;
        end else if (cycle_cnt_q == MAX_CYCLES - 32'd1) begin
          state_d = HALT;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_addr   = addr_q;
  assign imem_wdata  = buf_q;
  assign err         = err_q;
  assign word_count  = word_cnt_q;
  assign cycle_count = cycle_cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected IMEM writes are queued from a
// byte-level image model and popped by a monitor on every write strobe.
module tb_imem_loader;
  localparam int          AW    = 2;
  localparam int          DEPTH = 4;
  localparam logic [31:0] HPC   = 32'h80000078;
  localparam int          MAXC  = 16;

  logic          clk, rstn, start, s_valid, s_last, s_ready, imem_we;
  logic [7:0]    s_data;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata, cpu_pc, cycle_count;
  logic          cpu_rstn, running, halted, err;
  logic [AW:0]   word_count;

  imem_loader #(.ADDR_W(AW), .HALT_PC(HPC), .MAX_CYCLES(32'(MAXC))) dut (
    .clk(clk), .rstn(rstn), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_ready(s_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_rstn(cpu_rstn), .cpu_pc(cpu_pc), .running(running),
    .halted(halted), .err(err), .word_count(word_count), .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  img_q[$];
  logic [63:0] mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: actual addr=%0h data=%0h required no write", imem_addr, imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 64'(imem_addr), 64'(mon_e[63:32]));
        chk("wr_data", 64'(imem_wdata), 64'(mon_e[31:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    chk({tag, "_imem_we"}, 64'(imem_we), 64'd0);
    chk({tag, "_imem_addr"}, 64'(imem_addr), 64'd0);
    chk({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
    chk({tag, "_cpu_rstn"}, 64'(cpu_rstn), 64'd0);
    chk({tag, "_running"}, 64'(running), 64'd0);
    chk({tag, "_halted"}, 64'(halted), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_word_count"}, 64'(word_count), 64'd0);
    chk({tag, "_cycle_count"}, 64'(cycle_count), 64'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic lst, output bit ok);
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = b;
    s_last  = lst;
    for (int t = 0; t < 20; t++) begin
      if (s_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'($urandom);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL s_ready_wait: actual no ready for byte %0h required ready", b);
    end
  endtask

  task automatic do_run(input int halt_at, input int nw);
    int          c;
    int          exp_cc;
    logic [31:0] pc;
    logic        exp_err;
    chk("run_cpu_rstn", 64'(cpu_rstn), 64'd1);
    chk("run_word_count", 64'(word_count), 64'(nw));
    chk("run_err", 64'(err), 64'd0);
    chk("run_s_ready", 64'(s_ready), 64'd0);
    c = 1;
    while (running && c < 40) begin
      pc = $urandom;
      if (pc == HPC) pc = pc ^ 32'h1;
      cpu_pc = (c == halt_at) ? HPC : pc;
      start  = ($urandom_range(0, 3) == 0);
      tick();
      c++;
    end
    start  = 1'b0;
    cpu_pc = 32'h0;
    exp_err = !(halt_at >= 1 && halt_at <= MAXC);
    exp_cc  = exp_err ? MAXC : halt_at;
    chk("halt_halted", 64'(halted), 64'd1);
    chk("halt_running", 64'(running), 64'd0);
    chk("halt_cpu_rstn", 64'(cpu_rstn), 64'd0);
    chk("halt_cycle_count", 64'(cycle_count), 64'(exp_cc));
    chk("halt_err", 64'(err), 64'(exp_err));
    repeat (3) tick();
    chk("halt_cycle_frozen", 64'(cycle_count), 64'(exp_cc));
    chk("halt_word_frozen", 64'(word_count), 64'(nw));
    chk("halt_stays", 64'(halted), 64'd1);
  endtask

  task automatic do_load(input bit with_last, input int halt_at);
    int          n;
    int          nw;
    logic [31:0] w;
    bit          ok;
    n  = img_q.size();
    nw = (n + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      w = '0;
      for (int j = 0; j < 4; j++)
        if (4 * k + j < n) w[8*j +: 8] = img_q[4*k + j];
      exp_q.push_back({32'(k), w});
    end
    pulse_start();
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      send_byte(img_q[i], logic'(with_last && i == n - 1), ok);
      if (!ok) return;
    end
    chk("we_after_final_byte", 64'(imem_we), 64'd1);
    tick();
    chk("writes_drained", 64'(exp_q.size()), 64'd0);
    if (with_last) begin
      chk("run_after_write", 64'(running), 64'd1);
      do_run(halt_at, nw);
    end else begin
      chk("ovf_err", 64'(err), 64'd1);
      chk("ovf_s_ready", 64'(s_ready), 64'd0);
      chk("ovf_running", 64'(running), 64'd0);
      chk("ovf_word_count", 64'(word_count), 64'(DEPTH));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    rstn = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    s_data = 8'h0; cpu_pc = 32'h0;
    repeat (3) tick();
    check_reset_vals("rst");
    rstn = 1'b1;
    tick();

    img_q = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    do_load(1'b1, 5);
    img_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    do_load(1'b1, 10);
    img_q = '{8'h01, 8'h02, 8'h03};
    do_load(1'b1, 0);
    img_q = '{8'h5A};
    do_load(1'b1, MAXC);

    for (int r = 0; r < 8; r++) begin
      img_q.delete();
      repeat ($urandom_range(1, 16)) img_q.push_back(8'($urandom));
      do_load(1'b1, int'($urandom_range(1, 20)));
    end

    img_q.delete();
    repeat (16) img_q.push_back(8'($urandom));
    do_load(1'b0, 0);
    s_valid = 1'b1;
    s_last  = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("ovf_no_accept", 64'(s_ready), 64'd0);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;

    pulse_start();
    send_byte(8'h11, 1'b0, ok);
    send_byte(8'h22, 1'b0, ok);
    rstn = 1'b0;
    #1;
    check_reset_vals("midload_rst");
    tick();
    tick();
    rstn = 1'b1;
    tick();
    img_q = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h66, 8'h55};
    do_load(1'b1, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
